// File: rtl/apb_mem_pkg.sv
// Shared types and sizing helpers for the banked APB memory completer.
// Consumers: apb_mem_bank and apb_banked_mem_slave (optional macro APB_PSTRB_EN).
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    function automatic int bytes_of(input int width_data);
        return width_data / 8;
    endfunction

    // Index widths never collapse to zero so single-bank / single-row builds still elaborate.
    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    function automatic int row_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_mem_bank.sv
// One memory bank: DEPTH x WIDTH_DATA single-port RAM with byte write enables
// and a registered read port that holds its value until the next read.
module apb_mem_bank
    import apb_mem_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WIDTH_DATA = 32,
    localparam int BYTES     = bytes_of(WIDTH_DATA),
    localparam int ROW_W     = row_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [BYTES-1:0]      wr_be,
    input  logic [ROW_W-1:0]      addr,
    input  logic [WIDTH_DATA-1:0] wdata,
    output logic [WIDTH_DATA-1:0] rdata
);

    logic [WIDTH_DATA-1:0] mem [DEPTH];
    logic [WIDTH_DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < BYTES; b++) begin
            if (wr_be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (rd_en) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb_banked_mem_slave.sv
// APB3 completer over NUM_BANKS word-addressed banks with wait states, PSLVERR and abort.
// Define APB_PSTRB_EN to add the PSTRB byte-lane write-enable port.
module apb_banked_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int WIDTH_ADDR = 12,
    parameter int WIDTH_DATA = 32,
    parameter int NUM_BANKS  = 4,
    parameter int DEPTH      = 64,
    parameter int RD_WAIT    = 2,
    parameter int WR_WAIT    = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [WIDTH_ADDR-1:0]   PADDR,
    input  logic [WIDTH_DATA-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [WIDTH_DATA/8-1:0] PSTRB,
`endif
    output logic [WIDTH_DATA-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int BYTES  = bytes_of(WIDTH_DATA);
    localparam int OFF_W  = $clog2(BYTES);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int ROW_W  = row_w(DEPTH);
    localparam logic [WIDTH_ADDR:0]   WORDS_TOTAL = (WIDTH_ADDR+1)'(NUM_BANKS * DEPTH);
    localparam logic [WIDTH_ADDR-1:0] ALIGN_MASK  = WIDTH_ADDR'(BYTES - 1);

    logic [WIDTH_ADDR-1:0] word;
    logic [BANK_W-1:0]     bank_dec;
    logic [ROW_W-1:0]      row_dec;
    logic                  err_dec;
    logic [BYTES-1:0]      strb_in;

    assign word     = PADDR >> OFF_W;
    assign bank_dec = BANK_W'(word / DEPTH);
    assign row_dec  = ROW_W'(word % DEPTH);
    assign err_dec  = ((PADDR & ALIGN_MASK) != '0) || ({1'b0, word} >= WORDS_TOTAL);

`ifdef APB_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
    logic [BYTES-1:0]      strb_q, strb_d;
    logic                  setup;
    logic                  commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        bank_d  = bank_q;
        row_d   = row_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        setup   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup   = 1'b1;
                    write_d = PWRITE;
                    err_d   = err_dec;
                    bank_d  = bank_dec;
                    row_d   = row_dec;
                    wdata_d = PWDATA;
                    strb_d  = strb_in;
                    cnt_d   = PWRITE ? CNT_W'(WR_WAIT) : CNT_W'(RD_WAIT);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    if (!PSEL) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            bank_q  <= '0;
            row_q   <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            bank_q  <= bank_d;
            row_q   <= row_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // Reads use the freshly decoded row at SETUP; writes use the captured row at commit.
    logic [ROW_W-1:0]      bank_addr;
    logic [WIDTH_DATA-1:0] bank_rdata [NUM_BANKS];

    assign bank_addr = setup ? row_dec : row_q;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic             rd_en;
        logic [BYTES-1:0] wr_be;

        assign rd_en = PRESETn && setup && !PWRITE && !err_dec && (bank_dec == BANK_W'(gi));
        assign wr_be = (PRESETn && commit && write_q && !err_q && (bank_q == BANK_W'(gi)))
                       ? strb_q : '0;

        apb_mem_bank #(
            .DEPTH      (DEPTH),
            .WIDTH_DATA (WIDTH_DATA)
        ) u_bank (
            .clk   (PCLK),
            .rd_en (rd_en),
            .wr_be (wr_be),
            .addr  (bank_addr),
            .wdata (wdata_q),
            .rdata (bank_rdata[gi])
        );
    end

    logic [WIDTH_DATA-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == BANK_W'(b)) begin
                rd_mux = bank_rdata[b];
            end
        end
    end

    assign PREADY  = (state_q == ACCESS) && (cnt_q == '0);
    assign PSLVERR = PREADY && err_q;
    assign PRDATA  = (PREADY && !write_q && !err_q) ? rd_mux : '0;

endmodule

// File: tb/tb_apb_banked_mem_slave.sv
// Directed bench for apb_banked_mem_slave (default parameters); exercises PSTRB when
// APB_PSTRB_EN is defined. A transfer-level model drives per-cycle expectations.
module tb_apb_banked_mem_slave;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [11:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
`ifdef APB_PSTRB_EN
    logic [3:0]  PSTRB   = 4'hF;
`endif
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_banked_mem_slave dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
`ifdef APB_PSTRB_EN
        .PSTRB   (PSTRB),
`endif
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          chk_en  = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] mem_m [256];
    logic [31:0] last_rdata;
    logic        last_err;
    int          seen_k;

    // Every cycle: outputs must match what the transfer model says for this cycle.
    always @(negedge PCLK) begin
        if (chk_en) begin
            n_tests += 3;
            if (PREADY !== exp_ready) begin
                n_fail++;
                $display("FAIL pready t=%0t got %0b want %0b", $time, PREADY, exp_ready);
            end
            if (PSLVERR !== exp_err) begin
                n_fail++;
                $display("FAIL pslverr t=%0t got %0b want %0b", $time, PSLVERR, exp_err);
            end
            if (PRDATA !== exp_rdata) begin
                n_fail++;
                $display("FAIL prdata t=%0t got %08h want %08h", $time, PRDATA, exp_rdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got %08h want %08h", name, act, want);
        end else begin
            $display("[TB] %s ok (%08h)", name, act);
        end
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = '0;
    endtask

    // One APB transfer starting just after a rising edge. abort_k / rst_k (1-based ACCESS
    // cycle, 0 = never) drop PSEL or assert reset during that ACCESS cycle.
    task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int abort_k, input int rst_k);
        int       n;
        int       word;
        bit       err;
        bit       rdy;
        logic [3:0] strb_eff;
        word = int'(addr) / 4;
        err  = (int'(addr) % 4 != 0) || (word >= 4 * 64);
        n    = wr ? 1 : 2;
`ifdef APB_PSTRB_EN
        strb_eff = strb;
        PSTRB    = strb;
`else
        strb_eff = 4'hF;
`endif
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
        set_idle_exp();
        seen_k = 0; last_rdata = '0; last_err = 1'b0;
        @(posedge PCLK); #1;
        for (int k = 1; k <= n + 1; k++) begin
            if (k == abort_k) begin
                PSEL = 1'b0; PENABLE = 1'b0;
            end else begin
                PENABLE = 1'b1;
            end
            if (k == rst_k) PRESETn = 1'b0;
            rdy       = (k == n + 1);
            exp_ready = rdy;
            exp_err   = rdy && err;
            exp_rdata = (rdy && !wr && !err) ? mem_m[word] : 32'h0;
            @(negedge PCLK);
            if (PREADY && seen_k == 0) begin
                seen_k = k; last_rdata = PRDATA; last_err = PSLVERR;
            end
            @(posedge PCLK); #1;
            if (k == abort_k || k == rst_k) begin
                PSEL = 1'b0; PENABLE = 1'b0; PRESETn = 1'b1;
                set_idle_exp();
                @(posedge PCLK); #1;
                $display("[TB] %s 0x%03h cut at access cycle %0d", wr ? "WR" : "RD", addr, k);
                return;
            end
        end
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_eff[b]) mem_m[word][b*8 +: 8] = data[b*8 +: 8];
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        set_idle_exp();
        $display("[TB] %s 0x%03h data=%08h ready@%0d err=%0b rdata=%08h",
                 wr ? "WR" : "RD", addr, data, seen_k, last_err, last_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        chk_en = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("reset_pready", {31'b0, PREADY}, 32'h0);
        chk("reset_prdata", PRDATA, 32'h0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Basic write/read with latency
        xfer(1'b1, 12'h000, 32'h0BADF00D, 4'hF, 0, 0);
        xfer(1'b1, 12'h104, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("wr104_latency", seen_k, 32'd2);
        chk("wr104_pslverr", {31'b0, last_err}, 32'h0);
        xfer(1'b0, 12'h104, 32'h0, 4'hF, 0, 0);
        chk("rd104_latency", seen_k, 32'd3);
        chk("rd104_data", last_rdata, 32'hDEADBEEF);

        // Out-of-range and misaligned
        xfer(1'b0, 12'h400, 32'h0, 4'hF, 0, 0);
        chk("rd400_err", {31'b0, last_err}, 32'h1);
        chk("rd400_data", last_rdata, 32'h0);
        xfer(1'b0, 12'h102, 32'h0, 4'hF, 0, 0);
        chk("rd102_err", {31'b0, last_err}, 32'h1);
        xfer(1'b1, 12'h400, 32'h00000055, 4'hF, 0, 0);
        chk("wr400_err", {31'b0, last_err}, 32'h1);
        xfer(1'b0, 12'h000, 32'h0, 4'hF, 0, 0);
        chk("rd000_unchanged", last_rdata, 32'h0BADF00D);

        // Abort
        xfer(1'b1, 12'h010, 32'h11111111, 4'hF, 0, 0);
        xfer(1'b1, 12'h010, 32'h22222222, 4'hF, 1, 0);
        chk("abort_no_ready", seen_k, 32'd0);
        xfer(1'b0, 12'h010, 32'h0, 4'hF, 0, 0);
        chk("rd010_after_abort", last_rdata, 32'h11111111);

        // Reset in the middle of a write
        xfer(1'b1, 12'h020, 32'hAAAA5555, 4'hF, 0, 0);
        xfer(1'b1, 12'h020, 32'h12345678, 4'hF, 0, 1);
        xfer(1'b0, 12'h020, 32'h0, 4'hF, 0, 0);
        chk("rd020_after_reset", last_rdata, 32'hAAAA5555);

        // Back-to-back, one transfer per bank
        for (int i = 0; i < 4; i++) xfer(1'b1, 12'(i * 'h100), 32'hC0DE0000 + 32'(i * 17), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) xfer(1'b0, 12'(i * 'h100), 32'h0, 4'hF, 0, 0);
        chk("b2b_rd300", last_rdata, 32'hC0DE0033);

        // PENABLE without SETUP in IDLE must be ignored
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 12'h104; PWDATA = 32'h0;
        repeat (4) @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        xfer(1'b0, 12'h104, 32'h0, 4'hF, 0, 0);
        chk("rd104_after_violation", last_rdata, 32'hDEADBEEF);

`ifdef APB_PSTRB_EN
        xfer(1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 0, 0);
        xfer(1'b1, 12'h040, 32'h00000000, 4'b0101, 0, 0);
        xfer(1'b0, 12'h040, 32'h0, 4'hF, 0, 0);
        chk("pstrb_rd040", last_rdata, 32'hFF00FF00);
        xfer(1'b1, 12'h040, 32'h12345678, 4'b0000, 0, 0);
        chk("pstrb0_latency", seen_k, 32'd2);
        chk("pstrb0_err", {31'b0, last_err}, 32'h0);
        xfer(1'b0, 12'h040, 32'h0, 4'hF, 0, 0);
        chk("pstrb0_rd040", last_rdata, 32'hFF00FF00);
`endif

        @(posedge PCLK); #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
